pipe_hold_ctrl: RTL

Central pipeline-hold controller for the core. It arbitrates stall and flush requests from execute (jumps and multi-cycle ops), the rib bus and the clint. It drives the single hold_flag consumed by pc_reg, if_id and id_ex, and extends each flush over the fetch latency using a flush FSM. It also keeps a bus-hold watchdog and a stall-cycle performance counter.

---
 rtl/pipe_hold_ctrl_if.sv | 31 +++
 rtl/pipe_hold_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_hold_ctrl_if.sv
// Signal bundle between the pipeline hold controller and the stages that request and obey holds.
// Requests are plain levels sampled every cycle (no valid/ready); hold_flag_o answers in the same cycle.
interface pipe_hold_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             jump_flag_i;
    logic [31:0]      jump_addr_i;
    logic             hold_ex_i;
    logic             hold_rib_i;
    logic             hold_clint_i;
    logic             tmo_clr_i;
    logic [2:0]       hold_flag_o;
    logic             jump_flag_o;
    logic [31:0]      jump_addr_o;
    logic             flush_busy_o;
    logic             bus_timeout_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic             dbg_state;

    modport master (
        output jump_flag_i, jump_addr_i, hold_ex_i, hold_rib_i, hold_clint_i, tmo_clr_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o, flush_busy_o, bus_timeout_o,
               stall_cycles_o, dbg_state
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_ex_i, hold_rib_i, hold_clint_i, tmo_clr_i,
        output hold_flag_o, jump_flag_o, jump_addr_o, flush_busy_o, bus_timeout_o,
               stall_cycles_o, dbg_state
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold controller: merges ex/rib/clint hold requests, stretches flushes over the
// fetch latency with a small FSM, and keeps a bus-hold watchdog plus a stall-cycle counter.
module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 256,
    parameter int CNT_W        = 32
) (
    input logic             clk,
    input logic             rst,
    pipe_hold_ctrl_if.slave bus
);
    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam int FC_W = 4;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX     = WD_W'(TIMEOUT);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [FC_W-1:0]  cnt_q, cnt_d;
    logic             clint_q;
    logic [WD_W-1:0]  wd_q;
    logic             tmo_q;
    logic [CNT_W-1:0] stall_q;
    logic             trigger;
    logic [2:0]       req_level;
    logic [2:0]       fsm_level;
    logic [2:0]       hold;

    // A jump or a fresh interrupt entry (re)starts the flush window.
    always_comb begin
        trigger = bus.jump_flag_i | (bus.hold_clint_i & ~clint_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trigger && (FLUSH_CYCLES > 1)) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (trigger) begin
                    cnt_d = FLUSH_LOAD;
                end else if (cnt_q == FC_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        req_level = HOLD_NONE;
        fsm_level = HOLD_NONE;
        hold      = HOLD_NONE;
        if (bus.jump_flag_i || bus.hold_clint_i || bus.hold_ex_i) begin
            req_level = HOLD_ID;
        end else if (bus.hold_rib_i) begin
            req_level = HOLD_PC;
        end
        if (state_q == FLUSH) begin
            fsm_level = HOLD_IF;
        end
        // Inputs are masked while reset is asserted so nothing downstream stalls.
        if (rst) begin
            hold = (req_level > fsm_level) ? req_level : fsm_level;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clint_q <= 1'b0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clint_q <= bus.hold_clint_i;
            if (!bus.hold_rib_i) begin
                wd_q <= '0;
            end else if (wd_q != WD_MAX) begin
                wd_q <= wd_q + WD_W'(1);
            end
            // Setting beats a simultaneous clear so a timeout is never lost.
            if (wd_q == WD_MAX) begin
                tmo_q <= 1'b1;
            end else if (bus.tmo_clr_i) begin
                tmo_q <= 1'b0;
            end
            if (hold != HOLD_NONE) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bus.hold_flag_o    = hold;
    assign bus.jump_flag_o    = rst & bus.jump_flag_i;
    assign bus.jump_addr_o    = rst ? bus.jump_addr_i : 32'd0;
    assign bus.flush_busy_o   = (state_q == FLUSH);
    assign bus.bus_timeout_o  = tmo_q;
    assign bus.stall_cycles_o = stall_q;
    assign bus.dbg_state      = state_q;
endmodule
